// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
//
// Keypad-driven controller for the 16-bit registered calculator ALU. It builds
// operand A and operand B from decimal digits and latches the operator key. On
// "equals" it presents the operands and opcode to the ALU for ALU_LATENCY+1
// cycles, then captures the ALU result and holds it for display.
//
// Optional feature (macro CALC_CHAIN_EN):
//   defined   - an add/subtract key in SHOW chains a non-negative result into
//               operand A and starts entry of operand B.
//   undefined - an operator key in SHOW is rejected with a key_err pulse.
//
// Parameters:
//   MAX_DIGITS   decimal digits accepted per operand; later digits are ignored
//   ALU_LATENCY  cycles from the ALU sampling its inputs to a valid result
//
// Ports:
//   clk            system clock, rising edge
//   clear_n        asynchronous active-low reset
//   key_valid      one-cycle key strobe
//   key_code[3:0]  0-9 digit, A add, B subtract, C soft clear, E equals
//   alu_result     ALU result (17 bits)
//   alu_sign       ALU sign flag, 1 = negative subtraction result
//   num1/num2      ALU operands A/B (always reflect the operand registers)
//   op_selected    ALU opcode: 00 idle, 01 add, 10 subtract (only during EXEC)
//   busy           high during EXEC
//   result_valid   one-cycle pulse when a result is captured
//   display_value  value to show
//   display_neg    sign to show
//   key_err        one-cycle pulse when a key is rejected
// -----------------------------------------------------------------------------
module calc_sequencer #(
  parameter int MAX_DIGITS  = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [16:0] alu_result,
  input  logic        alu_sign,
  output logic [15:0] num1,
  output logic [15:0] num2,
  output logic [1:0]  op_selected,
  output logic        busy,
  output logic        result_valid,
  output logic [16:0] display_value,
  output logic        display_neg,
  output logic        key_err
);

  localparam int DCW = (MAX_DIGITS > 0) ? $clog2(MAX_DIGITS + 1) : 1;
  localparam int ECW = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

  localparam logic [DCW-1:0] DIGIT_MAX = DCW'(MAX_DIGITS);
  localparam logic [ECW-1:0] EXEC_LAST = ECW'(ALU_LATENCY);

  localparam logic [3:0] KEY_ADD   = 4'hA;
  localparam logic [3:0] KEY_SUB   = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_EQ    = 4'hE;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    ENTRY_B = 2'd1,
    EXEC    = 2'd2,
    SHOW    = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    opa_q, opa_d;
  logic [15:0]    opb_q, opb_d;
  logic [DCW-1:0] cnt_a_q, cnt_a_d;
  logic [DCW-1:0] cnt_b_q, cnt_b_d;
  logic [1:0]     op_q, op_d;
  logic [16:0]    res_q, res_d;
  logic           neg_q, neg_d;
  logic [ECW-1:0] exec_cnt_q, exec_cnt_d;
  logic           result_valid_q, result_valid_d;
  logic           key_err_q, key_err_d;

  // Key decode.
  logic       is_digit;
  logic       is_op;
  logic [1:0] key_op;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_op    = key_valid && ((key_code == KEY_ADD) || (key_code == KEY_SUB));
  assign key_op   = (key_code == KEY_ADD) ? OP_ADD : OP_SUB;

  // Decimal shift-in, deliberately truncated to 16 bits.
  function automatic logic [15:0] shift_in(input logic [15:0] v, input logic [3:0] d);
    return v * 16'd10 + {12'd0, d};
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q        <= ENTRY_A;
      opa_q          <= '0;
      opb_q          <= '0;
      cnt_a_q        <= '0;
      cnt_b_q        <= '0;
      op_q           <= OP_IDLE;
      res_q          <= '0;
      neg_q          <= 1'b0;
      exec_cnt_q     <= '0;
      result_valid_q <= 1'b0;
      key_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      cnt_a_q        <= cnt_a_d;
      cnt_b_q        <= cnt_b_d;
      op_q           <= op_d;
      res_q          <= res_d;
      neg_q          <= neg_d;
      exec_cnt_q     <= exec_cnt_d;
      result_valid_q <= result_valid_d;
      key_err_q      <= key_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    opa_d          = opa_q;
    opb_d          = opb_q;
    cnt_a_d        = cnt_a_q;
    cnt_b_d        = cnt_b_q;
    op_d           = op_q;
    res_d          = res_q;
    neg_d          = neg_q;
    exec_cnt_d     = exec_cnt_q;
    result_valid_d = 1'b0;
    key_err_d      = 1'b0;

    unique case (state_q)
      ENTRY_A: begin
        if (is_digit) begin
          if (cnt_a_q < DIGIT_MAX) begin
            opa_d   = shift_in(opa_q, key_code);
            cnt_a_d = cnt_a_q + 1'b1;
          end
        end else if (is_op) begin
          op_d    = key_op;
          opb_d   = '0;
          cnt_b_d = '0;
          state_d = ENTRY_B;
        end
      end

      ENTRY_B: begin
        if (is_digit) begin
          if (cnt_b_q < DIGIT_MAX) begin
            opb_d   = shift_in(opb_q, key_code);
            cnt_b_d = cnt_b_q + 1'b1;
          end
        end else if (is_op) begin
          op_d = key_op;
        end else if (key_valid && (key_code == KEY_EQ)) begin
          // opb_q is already zero when no B digit was entered.
          exec_cnt_d = '0;
          state_d    = EXEC;
        end
      end

      EXEC: begin
        // Every key is rejected, including one in the capture cycle.
        key_err_d = key_valid;
        if (exec_cnt_q == EXEC_LAST) begin
          res_d          = alu_result;
          neg_d          = alu_sign;
          result_valid_d = 1'b1;
          state_d        = SHOW;
        end else begin
          exec_cnt_d = exec_cnt_q + 1'b1;
        end
      end

      SHOW: begin
        if (is_digit) begin
          opa_d   = {12'd0, key_code};
          cnt_a_d = DCW'(1);
          state_d = ENTRY_A;
        end else if (is_op) begin
`ifdef CALC_CHAIN_EN
          // Only a non-negative result that fits in 16 bits can become A.
          if (!neg_q && !res_q[16]) begin
            opa_d   = res_q[15:0];
            op_d    = key_op;
            opb_d   = '0;
            cnt_b_d = '0;
            state_d = ENTRY_B;
          end else begin
            key_err_d = 1'b1;
          end
`else
          key_err_d = 1'b1;
`endif
        end
      end

      default: state_d = ENTRY_A;
    endcase

    // Soft clear overrides everything except a running calculation.
    if (key_valid && (key_code == KEY_CLEAR) && (state_q != EXEC)) begin
      opa_d   = '0;
      opb_d   = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      op_d    = OP_IDLE;
      res_d   = '0;
      neg_d   = 1'b0;
      state_d = ENTRY_A;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy          = (state_q == EXEC);
    op_selected   = busy ? op_q : OP_IDLE;
    num1          = opa_q;
    num2          = opb_q;
    result_valid  = result_valid_q;
    key_err       = key_err_q;
    display_neg   = (state_q == SHOW) ? neg_q : 1'b0;
    display_value = {1'b0, opa_q};
    unique case (state_q)
      ENTRY_A: display_value = {1'b0, opa_q};
      ENTRY_B: display_value = (cnt_b_q != '0) ? {1'b0, opb_q} : {1'b0, opa_q};
      EXEC,
      SHOW:    display_value = res_q;
      default: display_value = {1'b0, opa_q};
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_sequencer
//
// Directed test of calc_sequencer with a small registered ALU model
// (latency 1: add, or subtract returning magnitude plus sign). Keys are driven
// on the falling edge and outputs are sampled on the falling edge, half a
// cycle after the rising edge that updates the design.
// -----------------------------------------------------------------------------
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [16:0] alu_result;
  logic        alu_sign;
  logic [15:0] num1;
  logic [15:0] num2;
  logic [1:0]  op_selected;
  logic        busy;
  logic        result_valid;
  logic [16:0] display_value;
  logic        display_neg;
  logic        key_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  calc_sequencer #(
    .MAX_DIGITS  (4),
    .ALU_LATENCY (1)
  ) dut (
    .clk           (clk),
    .clear_n       (clear_n),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .alu_result    (alu_result),
    .alu_sign      (alu_sign),
    .num1          (num1),
    .num2          (num2),
    .op_selected   (op_selected),
    .busy          (busy),
    .result_valid  (result_valid),
    .display_value (display_value),
    .display_neg   (display_neg),
    .key_err       (key_err)
  );

  // Registered ALU: one cycle from sampling inputs to valid result.
  always @(posedge clk) begin
    if (op_selected == 2'b01) begin
      alu_result <= {1'b0, num1} + {1'b0, num2};
      alu_sign   <= 1'b0;
    end else if (op_selected == 2'b10) begin
      if (num1 >= num2) begin
        alu_result <= {1'b0, num1 - num2};
        alu_sign   <= 1'b0;
      end else begin
        alu_result <= {1'b0, num2 - num1};
        alu_sign   <= 1'b1;
      end
    end else begin
      alu_result <= '0;
      alu_sign   <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge, i.e. in the
  // cycle after the key was sampled.
  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_num1"}, 32'(num1), 0);
    check({tag, "_num2"}, 32'(num2), 0);
    check({tag, "_op"}, 32'(op_selected), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rv"}, 32'(result_valid), 0);
    check({tag, "_disp"}, 32'(display_value), 0);
    check({tag, "_neg"}, 32'(display_neg), 0);
    check({tag, "_kerr"}, 32'(key_err), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rv_seen;
    alu_result = '0;
    alu_sign   = 1'b0;
    key_valid  = 1'b0;
    key_code   = 4'h0;
    clear_n    = 1'b1;
    #2 clear_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    clear_n = 1'b1;
    @(negedge clk);

    // ---- basic add: 5 + 3 ----
    press(4'h5);
    check("add_dispA", 32'(display_value), 5);
    press(4'hA);
    check("add_dispB_empty", 32'(display_value), 5);
    press(4'h3);
    check("add_dispB", 32'(display_value), 3);
    press(4'hE);                          // cycle t+1
    check("add_busy1", 32'(busy), 1);
    check("add_num1", 32'(num1), 5);
    check("add_num2", 32'(num2), 3);
    check("add_op", 32'(op_selected), 1);
    check("add_rv1", 32'(result_valid), 0);
    @(negedge clk);                       // cycle t+2
    check("add_busy2", 32'(busy), 1);
    check("add_rv2", 32'(result_valid), 0);
    @(negedge clk);                       // cycle t+3
    check("add_rv3", 32'(result_valid), 1);
    check("add_result", 32'(display_value), 8);
    check("add_neg", 32'(display_neg), 0);
    check("add_busy3", 32'(busy), 0);
    check("add_op_idle", 32'(op_selected), 0);
    @(negedge clk);
    check("add_rv_pulse", 32'(result_valid), 0);
    check("add_hold", 32'(display_value), 8);

    // ---- negative subtract: 16 - 26 ----
    press(4'h1);
    press(4'h6);
    press(4'hB);
    check("sub_dispA", 32'(display_value), 16);
    press(4'h2);
    press(4'h6);
    press(4'hE);
    check("sub_op", 32'(op_selected), 2);
    check("sub_num1", 32'(num1), 16);
    check("sub_num2", 32'(num2), 26);
    repeat (2) @(negedge clk);
    check("sub_rv", 32'(result_valid), 1);
    check("sub_result", 32'(display_value), 10);
    check("sub_neg", 32'(display_neg), 1);
    // operator after a negative result is rejected in every build
    press(4'hB);
    check("neg_chain_kerr", 32'(key_err), 1);
    check("neg_chain_disp", 32'(display_value), 10);
    check("neg_chain_neg", 32'(display_neg), 1);
    check("neg_chain_busy", 32'(busy), 0);
    @(negedge clk);
    check("kerr_pulse", 32'(key_err), 0);

    // ---- digit limit ----
    press(4'hC);
    check("clr1_disp", 32'(display_value), 0);
    check("clr1_neg", 32'(display_neg), 0);
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    press(4'h5);
    check("limit_num1", 32'(num1), 1234);
    check("limit_disp", 32'(display_value), 1234);
    press(4'hE);                          // equals ignored in ENTRY_A
    check("eqA_busy", 32'(busy), 0);
    check("eqA_kerr", 32'(key_err), 0);
    check("eqA_disp", 32'(display_value), 1234);

    // ---- busy rejection: 7 + 7 with keys during EXEC ----
    press(4'hC);
    press(4'h7);
    press(4'hA);
    press(4'h7);
    press(4'hE);                          // cycle t+1
    press(4'h9);                          // sampled in t+1, now t+2
    check("exec_kerr1", 32'(key_err), 1);
    check("exec_busy", 32'(busy), 1);
    press(4'h9);                          // sampled in last EXEC cycle, now t+3
    check("exec_kerr_last", 32'(key_err), 1);
    check("exec_rv", 32'(result_valid), 1);
    check("exec_result", 32'(display_value), 14);
    check("exec_busy_done", 32'(busy), 0);

    // ---- chaining ----
    press(4'hA);
`ifdef CALC_CHAIN_EN
    check("chain_kerr", 32'(key_err), 0);
    check("chain_num1", 32'(num1), 14);
    check("chain_disp", 32'(display_value), 14);
    press(4'h1);
    press(4'hE);
    check("chain_op", 32'(op_selected), 1);
    repeat (2) @(negedge clk);
    check("chain_rv", 32'(result_valid), 1);
    check("chain_result", 32'(display_value), 15);
`else
    check("nochain_kerr", 32'(key_err), 1);
    check("nochain_disp", 32'(display_value), 14);
    check("nochain_busy", 32'(busy), 0);
    @(negedge clk);
    check("nochain_hold", 32'(display_value), 14);
`endif

    // ---- soft clear ----
    press(4'hC);
    check_all_zero("softclr");
    press(4'h3);
    check("softclr_entryA", 32'(display_value), 3);
    press(4'hC);

    // ---- reset mid-EXEC: 5 + (no digits) ----
    press(4'h5);
    press(4'hA);
    press(4'hE);                          // first EXEC cycle
    check("abort_busy", 32'(busy), 1);
    check("abort_num1", 32'(num1), 5);
    check("abort_num2_empty", 32'(num2), 0);
    #1 clear_n = 1'b0;
    #1 check_all_zero("abort");
    rv_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    clear_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    check("abort_no_rv", 32'(rv_seen), 0);
    check("abort_idle", 32'(busy), 0);
    press(4'h4);
    check("abort_entryA", 32'(display_value), 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
